// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_code_t;

endpackage

// File: rtl/ps2_code_fifo.sv
// Small FIFO of decoded scan codes. The head entry drives the outputs directly.
// A push is accepted when full only if a pop happens in the same cycle.
module ps2_code_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      CLK,
    input  logic      reset,
    input  logic      push,
    input  ps2_code_t push_data,
    input  logic      pop,
    output ps2_code_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    ps2_code_t      mem_reg [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           pop_ok;
    logic           push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    // A pop on an empty FIFO is ignored, so a simultaneous push simply becomes the head.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 receive front end: line synchronizers, 11-bit frame checker, E0/F0 prefix
// folding and a small output FIFO offered over valid/ready.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_code,
    output logic       out_brk,
    output logic       out_ext,
    output logic       frame_err,
    output logic       overflow
);

    localparam int             TW      = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0] line_raw;
    logic [1:0] line_sync;
    logic       clk_prev_reg;
    logic       bit_stb;
    logic       data_bit;

    assign line_raw = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge CLK) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= line_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign line_sync[gi] = sync_reg;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (reset) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= line_sync[0];
        end
    end

    assign bit_stb  = clk_prev_reg & ~line_sync[0];
    assign data_bit = line_sync[1];

    ps2_state_t     state_reg;
    logic [2:0]     bit_cnt_reg;
    logic [7:0]     shift_reg;
    logic           parity_reg;
    logic           accept_reg;
    logic           frame_err_reg;
    logic [TW-1:0]  timeout_cnt_reg;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            accept_reg      <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_cnt_reg <= '0;
        end else begin
            accept_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            if ((state_reg == IDLE) || bit_stb) begin
                timeout_cnt_reg <= '0;
            end else begin
                timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            end

            if (bit_stb) begin
                case (state_reg)
                    IDLE: begin
                        // A high start bit is line noise; wait quietly for a real start.
                        if (!data_bit) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg   <= {data_bit, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_reg <= data_bit;
                        state_reg  <= STOP;
                    end
                    STOP: begin
                        state_reg <= IDLE;
                        if (data_bit && ((^shift_reg) ^ parity_reg)) begin
                            accept_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end else if ((state_reg != IDLE) && (timeout_cnt_reg == TO_LAST)) begin
                state_reg       <= IDLE;
                frame_err_reg   <= 1'b1;
                timeout_cnt_reg <= '0;
            end
        end
    end

    logic      ext_reg;
    logic      brk_reg;
    logic      is_prefix;
    logic      push;
    ps2_code_t push_data;

    assign is_prefix = (shift_reg == PS2_EXT) || (shift_reg == PS2_BRK);
    assign push      = accept_reg & ~is_prefix;
    assign push_data = '{ext: ext_reg, brk: brk_reg, code: shift_reg};

    // Prefixes only modify the next real code; any framing error discards them.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (frame_err_reg) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (accept_reg) begin
            if (shift_reg == PS2_EXT) begin
                ext_reg <= 1'b1;
            end else if (shift_reg == PS2_BRK) begin
                brk_reg <= 1'b1;
            end else begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

    ps2_code_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;
    logic      overflow_reg;

    assign pop = out_valid & out_ready;

    ps2_code_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= push & fifo_full & ~pop;
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_code  = head.code;
    assign out_brk   = head.brk;
    assign out_ext   = head.ext;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: bit-banged PS/2 frames, a queue of
// expected codes checked as the consumer pops them, and pulse counters.
module tb_ps2_scan_sequencer;
    import ps2_pkg::*;

    localparam int TO    = 200;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_code;
    logic       out_brk;
    logic       out_ext;
    logic       frame_err;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_scan_sequencer #(
        .TIMEOUT_CYC(TO),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_code (out_code),
        .out_brk  (out_brk),
        .out_ext  (out_ext),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    int         checks = 0;
    int         errors = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         fe_exp = 0;
    int         ov_exp = 0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: count pulse cycles and compare each popped entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (overflow) ov_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_entry", {22'b0, out_ext, out_brk, out_code}, 32'h3FF);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("pop_entry", {22'b0, out_ext, out_brk, out_code}, {22'b0, e});
                    $display("pop code=%02h ext=%0b brk=%0b expected=%03h", out_code, out_ext, out_brk, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic d);
        ps2_data = d;
        cyc(5);
        ps2_clk = 1'b0;
        cyc(10);
        ps2_clk = 1'b1;
        cyc(5);
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par = 1'b0, input logic stop = 1'b1);
        logic par;
        par = (~^b) ^ bad_par;
        if (!bad_par && stop) begin
            if (b == PS2_EXT) begin
                m_ext = 1'b1;
            end else if (b == PS2_BRK) begin
                m_brk = 1'b1;
            end else begin
                if (!out_ready && exp_q.size() >= DEPTH) ov_exp++;
                else exp_q.push_back({m_ext, m_brk, b});
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end else begin
            fe_exp++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        $display("send byte=%02h bad_par=%0b stop=%0b", b, bad_par, stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
        cyc(5);
    endtask

    task automatic finish_step(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            cyc(1);
            n++;
        end
        cyc(5);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_frame_err"}, fe_cnt, fe_exp);
        check({tag, "_overflow"}, ov_cnt, ov_exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_code"}, out_code, 0);
        check({tag, "_brk"}, out_brk, 0);
        check({tag, "_ext"}, out_ext, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cyc(4);
        check_reset_outputs("reset");
        reset = 1'b0;
        cyc(4);

        // 1: single plain code
        out_ready = 1'b1;
        send(8'h1C);
        finish_step("t1");

        // 2: release prefix applies to one code only
        send(8'hF0);
        send(8'h1C);
        send(8'h1C);
        finish_step("t2");

        // 3: extended release
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        finish_step("t3");

        // 4: bad parity, bad stop, then a clean release pair
        send(8'h1C, 1'b1, 1'b1);
        send(8'h1C, 1'b0, 1'b0);
        send(8'hF0);
        send(8'h1C);
        finish_step("t4");

        // 5: fill with consumer stalled, fifth code overflows
        out_ready = 1'b0;
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h23);
        send(8'h24);
        cyc(5);
        check("t5_valid_held", out_valid, 1);
        check("t5_head_code", out_code, 8'h1C);
        check("t5_overflow_early", ov_cnt, ov_exp);
        out_ready = 1'b1;
        finish_step("t5");
        cyc(2);
        check("t5_empty", out_valid, 0);

        // 6a: abandoned frame times out
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        fe_exp++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        cyc(TO + 20);
        check("t6_timeout_err", fe_cnt, fe_exp);
        send(8'h1C);
        finish_step("t6a");

        // 6b: reset mid-frame drops the pending E0 prefix and partial frame
        send(8'hE0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        reset = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        cyc(3);
        check_reset_outputs("t6_reset");
        reset = 1'b0;
        cyc(4);
        send(8'h1C);
        finish_step("t6b");
        check("final_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
